// File: rtl/median_ctrl.sv
// -----------------------------------------------------------------------------
// median_ctrl
//
// Control sequencer for a serial 9-pixel median operator. The pixel data and
// its strobe go straight to the operator; this block only watches the strobe,
// steps the operator through its compare-exchange / shift schedule and flags
// the cycle on which the operator output holds the median.
//
// Schedule for one window (cycle 1 = first DSI-high cycle):
//   cycles  1.. 9  load      BYP=1 (9 consecutive DSI-high cycles)
//   cycles 10..45  passes    pass k = 0..3: (8-k) cycles BYP=0, (k+1) cycles BYP=1
//   cycles 46..49  finish    BYP=0
//   cycle  50      done      BYP=1, DSO=1; DSI may start the next window here
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   asynchronous active-high reset
//   DSI   in   data strobe, high while the 9 window pixels are on DI
//   BYP   out  operator bypass select: 1 = shift, 0 = compare-exchange
//   DSO   out  one-cycle pulse: operator output holds the median
//   BUSY  out  high while a window is in flight, up to and including the DSO
//              cycle; registered, so it rises the cycle after the first DSI
//   ERR   out  sticky strobe-protocol error, cleared only by RST
//
// All outputs are registered and decoded from the next state, so none has a
// combinational path from DSI.
// -----------------------------------------------------------------------------
module median_ctrl #(
  parameter int N_PIXELS = 9,
  parameter int CNT_W    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic DSI,
  output logic BYP,
  output logic DSO,
  output logic BUSY,
  output logic ERR
);

  // The pass schedule below is only correct for a 3x3 window.
  if (N_PIXELS != 9) begin : g_bad_window
    $error("median_ctrl: N_PIXELS must be 9");
  end
  if ((1 << CNT_W) <= N_PIXELS) begin : g_bad_cnt_w
    $error("median_ctrl: CNT_W too narrow for the step counter");
  end

  // Derived schedule constants. A median of 9 needs (9-1)/2 = 4 selection
  // passes followed by a 4-cycle finishing compare run.
  localparam int N_PASSES = (N_PIXELS - 1) / 2;
  localparam int FIN_LEN  = (N_PIXELS - 1) / 2;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_PIXELS - 1);
  localparam logic [CNT_W-1:0] CMP_BASE  = CNT_W'(N_PIXELS - 2);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(N_PASSES - 1);
  localparam logic [CNT_W-1:0] FIN_LAST  = CNT_W'(FIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_SHF,
    S_FIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q,  step_d;   // load count in LOAD, step within phase otherwise
  logic [CNT_W-1:0] pass_q,  pass_d;   // pass index k
  logic             err_q,   err_d;
  logic             byp_q,   byp_d;
  logic             dso_q,   dso_d;
  logic             busy_q,  busy_d;

  // Last step index of the compare phase of pass k: the phase lasts 8-k cycles.
  logic [CNT_W-1:0] cmp_last;
  assign cmp_last = CMP_BASE - pass_q;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d = state_q;
    step_d  = step_q;
    pass_d  = pass_q;
    err_d   = err_q;

    // All phase-end tests use >= so that a corrupted counter still terminates
    // the phase rather than wrapping around.
    unique case (state_q)
      S_IDLE: begin
        if (DSI) begin
          state_d = S_LOAD;
          step_d  = CNT_W'(1);          // this cycle is load cycle 1
        end
      end

      S_LOAD: begin
        if (!DSI) begin
          // Strobe dropped before the window was complete: abandon it.
          err_d   = 1'b1;
          state_d = S_IDLE;
          step_d  = '0;
        end else if (step_q >= LOAD_LAST) begin
          state_d = S_CMP;
          step_d  = '0;
          pass_d  = '0;
        end else begin
          step_d  = step_q + 1'b1;
        end
      end

      S_CMP: begin
        if (step_q >= cmp_last) begin
          state_d = S_SHF;
          step_d  = '0;
        end else begin
          step_d  = step_q + 1'b1;
        end
      end

      S_SHF: begin
        // Shift phase of pass k lasts k+1 cycles.
        if (step_q >= pass_q) begin
          step_d = '0;
          if (pass_q >= PASS_LAST) begin
            state_d = S_FIN;
            pass_d  = '0;
          end else begin
            state_d = S_CMP;
            pass_d  = pass_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      S_FIN: begin
        if (step_q >= FIN_LAST) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d  = step_q + 1'b1;
        end
      end

      S_DONE: begin
        // A strobe on the DSO cycle starts the next window back-to-back.
        if (DSI) begin
          state_d = S_LOAD;
          step_d  = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        pass_d  = '0;
      end
    endcase

    // A strobe while the operator is computing corrupts its result, but the
    // schedule keeps running so downstream still sees a DSO for the window.
    if (DSI && (state_q inside {S_CMP, S_SHF, S_FIN})) begin
      err_d = 1'b1;
    end

    // Outputs are decoded from the next state and registered, so during a
    // cycle they describe the state the FSM occupies in that cycle.
    byp_d  = !(state_d inside {S_CMP, S_FIN});
    dso_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
      byp_q   <= 1'b1;
      dso_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed in the previous cycle, independent of statement order.
      state_q <= state_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      byp_q   <= byp_d;
      dso_q   <= dso_d;
      busy_q  <= busy_d;
    end
  end

  assign BYP  = byp_q;
  assign DSO  = dso_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_median_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_ctrl
//
// Self-checking bench for median_ctrl. Stimulus is issued window by window;
// for each window the reference model writes the expected BYP/BUSY values per
// absolute cycle, the cycle from which ERR must read 1, and pushes the
// expected DSO cycle into a scoreboard queue. An independent monitor samples
// the outputs on every falling edge and compares them with those expectations.
// -----------------------------------------------------------------------------
module tb_median_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dsi = 1'b0;
  logic byp, dso, busy, err;

  int cyc      = 0;      // number of the current clock cycle
  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model state.
  bit exp_byp  [int];    // absent entry -> 1 (idle / load value)
  bit exp_busy [int];    // absent entry -> 0
  int dso_q [$];         // scoreboard of expected DSO cycles
  int err_from = -1;     // first cycle ERR must be 1, -1 = never

  median_ctrl #(.N_PIXELS(9), .CNT_W(4)) dut (
    .CLK  (clk),
    .RST  (rst),
    .DSI  (dsi),
    .BYP  (byp),
    .DSO  (dso),
    .BUSY (busy),
    .ERR  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // BYP on cycle offset i of a window (i = 0 is the first DSI cycle).
  function automatic bit sched_byp(input int i);
    int j;
    if (i < 9)  return 1'b1;
    if (i >= 49) return 1'b1;
    if (i >= 45) return 1'b0;
    j = i - 9;
    for (int k = 0; k < 4; k++) begin
      if (j < 8 - k) return 1'b0;
      j -= 8 - k;
      if (j < k + 1) return 1'b1;
      j -= k + 1;
    end
    return 1'b1;
  endfunction

  function automatic void set_err(input int c);
    if (err_from < 0 || c < err_from) err_from = c;
  endfunction

  // Full 9-cycle load at cycle s; extra >= 0 is the offset of a stray strobe.
  function automatic void model_full(input int s, input int extra);
    for (int i = 0; i <= 49; i++) begin
      exp_byp[s + i] = sched_byp(i);
      if (i >= 1) exp_busy[s + i] = 1'b1;
    end
    dso_q.push_back(s + 49);
    if (extra >= 0) set_err(s + extra + 1);
  endfunction

  // Load aborted after len strobe cycles starting at s.
  function automatic void model_short(input int s, input int len);
    for (int i = 1; i <= len; i++) exp_busy[s + i] = 1'b1;
    set_err(s + len + 1);
  endfunction

  function automatic void model_reset(input int c);
    err_from = -1;
    dso_q.delete();
    for (int k = c; k < c + 64; k++) begin
      exp_byp.delete(k);
      exp_busy.delete(k);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    int  c;
    bit  eb, ebu, ee;
    c   = cyc;
    eb  = exp_byp.exists(c)  ? exp_byp[c]  : 1'b1;
    ebu = exp_busy.exists(c) ? exp_busy[c] : 1'b0;
    ee  = (err_from >= 0) && (c >= err_from);
    check("BYP",  int'(byp),  int'(eb));
    check("BUSY", int'(busy), int'(ebu));
    check("ERR",  int'(err),  int'(ee));
    if (dso) begin
      if (dso_q.size() == 0) check("DSO_cycle", c, -1);
      else                   check("DSO_cycle", c, dso_q.pop_front());
    end else if (dso_q.size() > 0 && dso_q[0] <= c) begin
      check("DSO_missing", int'(dso), 1);
      void'(dso_q.pop_front());
    end
    exp_byp.delete(c);
    exp_busy.delete(c);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input bit d);
    @(posedge clk);
    #1;
    dsi = d;
  endtask

  // Drives cycle offsets 0..48; the caller drives the DONE cycle (offset 49),
  // either idle or as the first cycle of the next window.
  task automatic window(input int extra);
    int s;
    step(1'b1);
    s = cyc;
    model_full(s, extra);
    for (int i = 1; i <= 48; i++) step((i <= 8) || (i == extra));
  endtask

  task automatic short_load(input int len);
    int s;
    step(1'b1);
    s = cyc;
    model_short(s, len);
    for (int i = 1; i < len; i++) step(1'b1);
    step(1'b0);
  endtask

  // Asserts RST partway through the current cycle and checks that the outputs
  // respond without waiting for a clock edge.
  task automatic async_reset();
    rst = 1'b1;
    model_reset(cyc);
    #1;
    check("RST_BYP",  int'(byp),  1);
    check("RST_DSO",  int'(dso),  0);
    check("RST_BUSY", int'(busy), 0);
    check("RST_ERR",  int'(err),  0);
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int r, g;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle.
    repeat (20) step(1'b0);

    // Single window.
    window(-1);
    repeat (6) step(1'b0);

    // Back-to-back windows: second strobe starts on the DSO cycle.
    window(-1);
    window(-1);
    repeat (6) step(1'b0);

    // Strobe re-asserted at sequence cycle 20, and a 10th consecutive strobe.
    window(19);
    repeat (3) step(1'b0);
    window(9);
    repeat (3) step(1'b0);

    // Reset at sequence cycle 30, then a clean window.
    step(1'b1);
    model_full(cyc, -1);
    for (int i = 1; i <= 28; i++) step(i <= 8);
    step(1'b0);
    async_reset();
    repeat (3) step(1'b0);
    window(-1);
    repeat (4) step(1'b0);

    // Short load, then ERR must stay set across 100 legal windows.
    short_load(5);
    repeat (3) step(1'b0);
    for (int w = 0; w < 100; w++) begin
      window(-1);
      step(1'b0);
    end
    step(1'b0);
    async_reset();
    repeat (3) step(1'b0);

    // Random regression with random gaps and occasional protocol errors.
    for (int w = 0; w < 600; w++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      short_load(int'($urandom_range(1, 8)));
      else if (r == 1) window(int'($urandom_range(9, 48)));
      else             window(-1);
      g = int'($urandom_range(0, 4));
      for (int i = 0; i < g; i++) step(1'b0);
    end
    repeat (10) step(1'b0);

    check("DSO_pending", dso_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
